port_multi: RTL and testbench

- Parametrised successor to the single-instance GPIO block: an AHB-Lite slave with NCH channels of WIDTH pins each.
- Per channel: direction and data registers, atomic set/clear/toggle aliases, a 2-FF input synchroniser, and rise/fall edge capture into sticky interrupt flags.
- One IRQ line per channel, routed to the interrupt controller.
- Pins are exposed as split I/O/OE vectors; the pad ring instantiates the tri-states.

---
 rtl/port_multi_pkg.sv | 23 ++
 rtl/port_multi_ch.sv | 121 ++++++++++++
 rtl/port_multi.sv | 98 +++++++++
 tb/tb_port_multi.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/port_multi_pkg.sv
// rtl/port_multi_pkg.sv - shared register map constants for the multi-channel GPIO port
//
// Purpose: register offsets, channel address stride and register index type
//          used by port_multi and port_multi_ch.
// Ports:   none (package).
package port_multi_pkg;

  typedef logic [2:0] reg_idx_t;

  // Register index = byte offset / 4 within one channel window
  localparam reg_idx_t REG_PDR  = 3'd0;
  localparam reg_idx_t REG_PDD  = 3'd1;
  localparam reg_idx_t REG_PSET = 3'd2;
  localparam reg_idx_t REG_PCLR = 3'd3;
  localparam reg_idx_t REG_PTGL = 3'd4;
  localparam reg_idx_t REG_IRE  = 3'd5;
  localparam reg_idx_t REG_IFE  = 3'd6;
  localparam reg_idx_t REG_IFLG = 3'd7;

  localparam logic [31:0] CH_STRIDE = 32'h20;
  localparam int          CH_LSB    = $clog2(CH_STRIDE);

endpackage

// File: rtl/port_multi_ch.sv
// rtl/port_multi_ch.sv - one GPIO channel: registers, input sync, edge flags, IRQ
//
// Purpose: holds PDR/PDD/IRE/IFE/IFLG for one channel, applies set/clear/toggle
//          aliases, synchronises the pad inputs and captures edges into sticky flags.
//          Optional per-pin debounce filter when PORT_DEBOUNCE_EN is defined.
// Ports:   i_clk, i_rst       clock, async active-high reset
//          i_wr_en/i_wr_reg   write strobe and register index, i_wdata write data
//          i_rd_reg           register index for o_rdata (combinational)
//          i_gpio             asynchronous pad inputs
//          o_gpio_o/o_gpio_oe pad output value / enable, o_irq channel interrupt
module port_multi_ch
  import port_multi_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEB_LEN = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  reg_idx_t         i_wr_reg,
  input  logic [WIDTH-1:0] i_wdata,
  input  reg_idx_t         i_rd_reg,
  input  logic [WIDTH-1:0] i_gpio,
  output logic [WIDTH-1:0] o_rdata,
  output logic [WIDTH-1:0] o_gpio_o,
  output logic [WIDTH-1:0] o_gpio_oe,
  output logic             o_irq
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("port_multi_ch: WIDTH must be 1..32");
  end
  if (DEB_LEN < 2 || DEB_LEN > 15) begin : g_bad_deb
    $error("port_multi_ch: DEB_LEN must be 2..15");
  end

  logic [WIDTH-1:0] r_pdr, r_pdd, r_ire, r_ife, r_iflg;
  logic [WIDTH-1:0] r_sync1, r_sync2, r_prev;
  logic [WIDTH-1:0] w_in, w_rise, w_fall, w_set, w_clr;

`ifdef PORT_DEBOUNCE_EN
  localparam logic [3:0] DEB_MAX = 4'(DEB_LEN - 1);
  logic [WIDTH-1:0] r_filt;
  logic [3:0]       r_cnt [WIDTH];

  // Filtered value follows sync2 only after it has differed for DEB_LEN cycles in a row
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_filt <= '0;
      for (int b = 0; b < WIDTH; b++) r_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < WIDTH; b++) begin
        if (r_sync2[b] == r_filt[b]) begin
          r_cnt[b] <= '0;
        end else if (r_cnt[b] == DEB_MAX) begin
          r_filt[b] <= r_sync2[b];
          r_cnt[b]  <= '0;
        end else begin
          r_cnt[b] <= r_cnt[b] + 4'd1;
        end
      end
    end
  end
  assign w_in = r_filt;
`else
  assign w_in = r_sync2;
`endif

  assign w_rise = w_in & ~r_prev;
  assign w_fall = ~w_in & r_prev;
  assign w_set  = (w_rise & r_ire) | (w_fall & r_ife);
  assign w_clr  = (i_wr_en && i_wr_reg == REG_IFLG) ? i_wdata : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pdr   <= '0;
      r_pdd   <= '0;
      r_ire   <= '0;
      r_ife   <= '0;
      r_iflg  <= '0;
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= i_gpio;
      r_sync2 <= r_sync1;
      r_prev  <= w_in;
      // A new edge overrides a same-cycle write-1-clear
      r_iflg  <= (r_iflg & ~w_clr) | w_set;
      if (i_wr_en) begin
        case (i_wr_reg)
          REG_PDR:  r_pdr <= i_wdata;
          REG_PDD:  r_pdd <= i_wdata;
          REG_PSET: r_pdr <= r_pdr | i_wdata;
          REG_PCLR: r_pdr <= r_pdr & ~i_wdata;
          REG_PTGL: r_pdr <= r_pdr ^ i_wdata;
          REG_IRE:  r_ire <= i_wdata;
          REG_IFE:  r_ife <= i_wdata;
          default:  ;
        endcase
      end
    end
  end

  always_comb begin
    o_rdata = '0;
    case (i_rd_reg)
      REG_PDR:  o_rdata = (r_pdd & r_pdr) | (~r_pdd & w_in);
      REG_PDD:  o_rdata = r_pdd;
      REG_IRE:  o_rdata = r_ire;
      REG_IFE:  o_rdata = r_ife;
      REG_IFLG: o_rdata = r_iflg;
      default:  o_rdata = '0;
    endcase
  end

  assign o_gpio_o  = r_pdr;
  assign o_gpio_oe = r_pdd;
  assign o_irq     = |(r_iflg & (r_ire | r_ife));

endmodule

// File: rtl/port_multi.sv
// rtl/port_multi.sv - AHB-Lite slave with NCH GPIO channels of WIDTH pins
//
// Purpose: captures the AHB address phase, performs zero-wait writes at the end of
//          the data phase and muxes read data from the addressed channel.
//          Optional debounce filter: define PORT_DEBOUNCE_EN.
// Ports:   CLK, RES                 clock, async active-high reset
//          S_H*                     AHB-Lite slave (HREADYOUT tied 1, HRESP tied 0)
//          GPIO_I/GPIO_O/GPIO_OE    pad input, output value, output enable (NCH*WIDTH)
//          IRQ                      one interrupt per channel
module port_multi
  import port_multi_pkg::*;
#(
  parameter int NCH     = 3,
  parameter int WIDTH   = 32,
  parameter int DEB_LEN = 4
) (
  input  logic                 CLK,
  input  logic                 RES,
  input  logic                 S_HSEL,
  input  logic [1:0]           S_HTRANS,
  input  logic                 S_HWRITE,
  input  logic                 S_HMASTLOCK,
  input  logic [2:0]           S_HSIZE,
  input  logic [2:0]           S_HBURST,
  input  logic [3:0]           S_HPROT,
  input  logic [31:0]          S_HADDR,
  input  logic [31:0]          S_HWDATA,
  input  logic                 S_HREADY,
  output logic                 S_HREADYOUT,
  output logic [31:0]          S_HRDATA,
  output logic                 S_HRESP,
  input  logic [NCH*WIDTH-1:0] GPIO_I,
  output logic [NCH*WIDTH-1:0] GPIO_O,
  output logic [NCH*WIDTH-1:0] GPIO_OE,
  output logic [NCH-1:0]       IRQ
);

  if (NCH < 1 || NCH > 8) begin : g_bad_nch
    $error("port_multi: NCH must be 1..8");
  end

  logic       r_dp_valid, r_dp_write;
  logic [2:0] r_dp_ch;
  reg_idx_t   r_dp_reg;
  logic       w_wr_go;
  logic [WIDTH-1:0] w_ch_rdata [NCH];

  // Size, burst, protection and lock carry no meaning for this register file
  logic w_unused;
  assign w_unused = &{1'b0, S_HMASTLOCK, S_HSIZE, S_HBURST, S_HPROT,
                      S_HADDR[31:8], S_HADDR[1:0], S_HTRANS[0], S_HWDATA};

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_ch    <= '0;
      r_dp_reg   <= '0;
    end else if (S_HREADY) begin
      r_dp_valid <= S_HSEL & S_HTRANS[1];
      r_dp_write <= S_HWRITE;
      r_dp_ch    <= S_HADDR[CH_LSB +: 3];
      r_dp_reg   <= S_HADDR[2 +: 3];
    end
  end

  assign w_wr_go = r_dp_valid & r_dp_write & S_HREADY;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    port_multi_ch #(.WIDTH(WIDTH), .DEB_LEN(DEB_LEN)) u_ch (
      .i_clk    (CLK),
      .i_rst    (RES),
      .i_wr_en  (w_wr_go && (r_dp_ch == 3'(i))),
      .i_wr_reg (r_dp_reg),
      .i_wdata  (S_HWDATA[WIDTH-1:0]),
      .i_rd_reg (r_dp_reg),
      .i_gpio   (GPIO_I[i*WIDTH +: WIDTH]),
      .o_rdata  (w_ch_rdata[i]),
      .o_gpio_o (GPIO_O[i*WIDTH +: WIDTH]),
      .o_gpio_oe(GPIO_OE[i*WIDTH +: WIDTH]),
      .o_irq    (IRQ[i])
    );
  end

  // Unmatched channel numbers fall through to zero
  always_comb begin
    S_HRDATA = '0;
    if (r_dp_valid && !r_dp_write) begin
      for (int i = 0; i < NCH; i++) begin
        if (r_dp_ch == 3'(i)) S_HRDATA[WIDTH-1:0] = w_ch_rdata[i];
      end
    end
  end

  assign S_HREADYOUT = 1'b1;
  assign S_HRESP     = 1'b0;

endmodule

// File: tb/tb_port_multi.sv
// tb/tb_port_multi.sv - self-checking bench for port_multi with a register-level model
module tb_port_multi;
  import port_multi_pkg::*;

  localparam int NCH     = 3;
  localparam int WIDTH   = 32;
  localparam int DEB_LEN = 4;
`ifdef PORT_DEBOUNCE_EN
  localparam int LAT = DEB_LEN + 3;
`else
  localparam int LAT = 3;
`endif
  localparam logic [31:0] MASK = (WIDTH == 32) ? 32'hFFFF_FFFF : ((32'd1 << WIDTH) - 32'd1);

  logic clk = 1'b0, res = 1'b1;
  logic hsel = 1'b0, hwrite = 1'b0, hready = 1'b1, hreadyout, hresp;
  logic [1:0]  htrans = 2'b00;
  logic [31:0] haddr = '0, hwdata = '0, hrdata;
  logic [NCH*WIDTH-1:0] gpio_i = '0, gpio_o, gpio_oe;
  logic [NCH-1:0] irq;

  int n_tests = 0, n_fail = 0;

  logic [31:0] m_pdr [8], m_pdd [8], m_ire [8], m_ife [8], m_iflg [8];
  logic [NCH*WIDTH-1:0] m_pin = '0;

  always #5 clk = ~clk;

  port_multi #(.NCH(NCH), .WIDTH(WIDTH), .DEB_LEN(DEB_LEN)) dut (
    .CLK(clk), .RES(res), .S_HSEL(hsel), .S_HTRANS(htrans), .S_HWRITE(hwrite),
    .S_HMASTLOCK(1'b0), .S_HSIZE(3'b010), .S_HBURST(3'b000), .S_HPROT(4'b0011),
    .S_HADDR(haddr), .S_HWDATA(hwdata), .S_HREADY(hready), .S_HREADYOUT(hreadyout),
    .S_HRDATA(hrdata), .S_HRESP(hresp), .GPIO_I(gpio_i), .GPIO_O(gpio_o),
    .GPIO_OE(gpio_oe), .IRQ(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < 8; c++) begin
      m_pdr[c] = '0; m_pdd[c] = '0; m_ire[c] = '0; m_ife[c] = '0; m_iflg[c] = '0;
    end
  endfunction

  function automatic void model_write(input int ch, input int rg, input logic [31:0] d);
    logic [31:0] v;
    v = d & MASK;
    if (ch >= NCH) return;
    case (rg)
      0: m_pdr[ch]  = v;
      1: m_pdd[ch]  = v;
      2: m_pdr[ch]  = m_pdr[ch] | v;
      3: m_pdr[ch]  = m_pdr[ch] & ~v;
      4: m_pdr[ch]  = m_pdr[ch] ^ v;
      5: m_ire[ch]  = v;
      6: m_ife[ch]  = v;
      default: m_iflg[ch] = m_iflg[ch] & ~v;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input int ch, input int rg);
    logic [31:0] p;
    if (ch >= NCH) return 32'h0;
    p = '0;
    p[WIDTH-1:0] = m_pin[ch*WIDTH +: WIDTH];
    case (rg)
      0: return (m_pdd[ch] & m_pdr[ch]) | (~m_pdd[ch] & p);
      1: return m_pdd[ch];
      5: return m_ire[ch];
      6: return m_ife[ch];
      7: return m_iflg[ch];
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_irq();
    logic [31:0] e;
    e = '0;
    for (int c = 0; c < NCH; c++) e[c] = |(m_iflg[c] & (m_ire[c] | m_ife[c]));
    return e;
  endfunction

  // New pin levels; flags the model expects once the change has propagated
  task automatic drive_pins(input logic [NCH*WIDTH-1:0] v);
    logic [31:0] o, n;
    for (int c = 0; c < NCH; c++) begin
      o = '0; n = '0;
      o[WIDTH-1:0] = m_pin[c*WIDTH +: WIDTH];
      n[WIDTH-1:0] = v[c*WIDTH +: WIDTH];
      m_iflg[c] = m_iflg[c] | (((n & ~o & m_ire[c]) | (~n & o & m_ife[c])) & MASK);
    end
    m_pin  = v;
    gpio_i = v;
  endtask

  task automatic ahb_write(input int ch, input int rg, input logic [31:0] d);
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = ch * CH_STRIDE + rg * 4;
    @(posedge clk); #1;
    hwdata = d; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
  endtask

  task automatic ahb_read(input int ch, input int rg, output logic [31:0] d);
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = ch * CH_STRIDE + rg * 4;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00;
    d = hrdata;
  endtask

  task automatic bus_wr(input int ch, input int rg, input logic [31:0] d);
    model_write(ch, rg, d);
    ahb_write(ch, rg, d);
  endtask

  task automatic bus_rd_chk(input string tag, input int ch, input int rg);
    logic [31:0] d;
    ahb_read(ch, rg, d);
    chk($sformatf("%s ch%0d r%0d", tag, ch, rg), d, model_read(ch, rg));
  endtask

  task automatic settle();
    repeat (LAT + 3) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [NCH*WIDTH-1:0] pv;
    model_reset();
    repeat (3) @(posedge clk);
    #1 res = 1'b0;

    // Reset state
    for (int c = 0; c <= NCH; c++)
      for (int r = 0; r < 8; r++) begin
        ahb_read(c, r, d);
        chk($sformatf("reset ch%0d r%0d", c, r), d, 32'h0);
      end
    for (int c = 0; c < NCH; c++) begin
      chk("reset oe", gpio_oe[c*WIDTH +: WIDTH], 32'h0);
      chk("reset o", gpio_o[c*WIDTH +: WIDTH], 32'h0);
    end
    chk("reset irq", 32'(irq), 32'h0);

    // Channel 1 set/clear/toggle sequence
    bus_wr(1, REG_PDD, 32'h0000FFFF);
    bus_wr(1, REG_PDR, 32'h000000F0);
    bus_wr(1, REG_PSET, 32'h0000000F);
    bus_wr(1, REG_PCLR, 32'h00000050);
    bus_wr(1, REG_PTGL, 32'h00000001);
    bus_wr(1, REG_PTGL, 32'h00000004);
    bus_rd_chk("ch1 pdr", 1, REG_PDR);
    chk("ch1 gpio_o", gpio_o[WIDTH +: WIDTH], 32'h000000AA);
    chk("ch1 gpio_oe", gpio_oe[WIDTH +: WIDTH], 32'h0000FFFF);

    // Back-to-back write then read of the same register
    model_write(1, REG_PDD, 32'h12345678);
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 1 * CH_STRIDE + REG_PDD * 4;
    @(posedge clk); #1;
    hwdata = 32'h12345678; hwrite = 1'b0;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00;
    chk("b2b read", hrdata, 32'h12345678);

    // Rising edge on ch0 bit3: flag and IRQ exactly LAT clocks after the pin change
    bus_wr(0, REG_IRE, 32'h8);
    @(posedge clk); #1;
    pv = m_pin; pv[3] = 1'b1;
    drive_pins(pv);
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk); #1;
      chk($sformatf("irq0 lat k%0d", k), 32'(irq[0]), (k == LAT) ? 32'h1 : 32'h0);
    end
    bus_rd_chk("iflg0", 0, REG_IFLG);
    bus_wr(0, REG_IFLG, 32'h8);
    @(posedge clk); #1;
    chk("irq0 cleared", 32'(irq[0]), 32'h0);

    // Ch2 falling edge meets a write-1-clear in the same cycle: set wins
    pv = m_pin; pv[2*WIDTH] = 1'b1;
    drive_pins(pv);
    settle();
    bus_wr(2, REG_IFE, 32'h1);
    @(posedge clk); #1;
    pv = m_pin; pv[2*WIDTH] = 1'b0;
    drive_pins(pv);
    repeat (LAT - 2) @(posedge clk);
    #1;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 2 * CH_STRIDE + REG_IFLG * 4;
    @(posedge clk); #1;
    hwdata = 32'h1; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
    bus_rd_chk("set wins", 2, REG_IFLG);
    chk("set wins irq2", 32'(irq[2]), 32'h1);
    bus_wr(2, REG_IFLG, 32'h1);
    bus_rd_chk("ch2 clr", 2, REG_IFLG);

`ifdef PORT_DEBOUNCE_EN
    // Debounce: short glitch ignored, long pulse flagged after DEB_LEN+3 clocks
    bus_wr(0, REG_IRE, 32'h1);
    bus_wr(0, REG_IFLG, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    gpio_i[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1 gpio_i[0] = 1'b0;
    repeat (12) @(posedge clk);
    bus_rd_chk("deb glitch", 0, REG_IFLG);
    @(posedge clk); #1;
    pv = m_pin; pv[0] = 1'b1;
    drive_pins(pv);
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk); #1;
      chk($sformatf("deb lat k%0d", k), 32'(irq[0]), (k == LAT) ? 32'h1 : 32'h0);
      if (k == 6) begin
        pv = m_pin; pv[0] = 1'b0;
        drive_pins(pv);
      end
    end
    bus_rd_chk("deb flag", 0, REG_IFLG);
`endif

    // Randomised rounds: pin changes, then random register traffic
    for (int rnd = 0; rnd < 20; rnd++) begin
      for (int c = 0; c < NCH; c++) pv[c*WIDTH +: WIDTH] = WIDTH'($urandom & MASK);
      drive_pins(pv);
      settle();
      chk($sformatf("rnd%0d irq", rnd), 32'(irq), model_irq());
      for (int c = 0; c < NCH; c++) bus_rd_chk("rnd iflg", c, REG_IFLG);
      for (int op = 0; op < 15; op++) begin
        int c, r;
        c = $urandom_range(0, (NCH < 8) ? NCH : 7);
        r = $urandom_range(0, 7);
        if ($urandom_range(0, 1) == 1) bus_wr(c, r, $urandom);
        else bus_rd_chk("rnd rd", c, r);
      end
      @(posedge clk); #1;
      chk($sformatf("rnd%0d irq post", rnd), 32'(irq), model_irq());
      for (int c = 0; c < NCH; c++) chk("rnd gpio_o", gpio_o[c*WIDTH +: WIDTH], m_pdr[c]);
    end

    // Reset asserted during a write data phase
    drive_pins('0);
    settle();
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 1 * CH_STRIDE + REG_PDR * 4;
    @(posedge clk); #1;
    hwdata = 32'hDEAD_BEEF; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
    #2 res = 1'b1;
    #1 chk("rst hrdata", hrdata, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 res = 1'b0;
    for (int c = 0; c < NCH; c++)
      for (int r = 0; r < 8; r++) begin
        ahb_read(c, r, d);
        chk($sformatf("post-rst ch%0d r%0d", c, r), d, 32'h0);
      end
    for (int c = 0; c < NCH; c++) begin
      chk("post-rst o", gpio_o[c*WIDTH +: WIDTH], 32'h0);
      chk("post-rst oe", gpio_oe[c*WIDTH +: WIDTH], 32'h0);
    end
    chk("post-rst irq", 32'(irq), 32'h0);
    chk("hreadyout", 32'(hreadyout), 32'h1);
    chk("hresp", 32'(hresp), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
